button_event_fsm: RTL and testbench
===================================

BUTTON_EVENT_FSM -- requirements
Module: button_event_fsm

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 1000: cycles the input must stay high before a long press is declared; legal range 2 to 65535.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 250: period in cycles of repeat pulses during a long press; legal range 2 to 65535.
REQ-003 SHALL have parameter CNT_W, default 8: width of press_count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port debounced_in, input, 1 bit: debounced button level, synchronous to clk, 1 = pressed.
REQ-007 SHALL have port clear_count, input, 1 bit: synchronous clear of press_count.
REQ-008 SHALL have port press_pulse, output, 1 bit: one-cycle strobe per new press.
REQ-009 SHALL have port release_pulse, output, 1 bit: one-cycle strobe per release.
REQ-010 SHALL have port long_pulse, output, 1 bit: one-cycle strobe when a press becomes long.
REQ-011 SHALL have port repeat_pulse, output, 1 bit: periodic strobe while a long press is held.
REQ-012 SHALL have port long_active, output, 1 bit: level, high while in HELD.
REQ-013 SHALL have port press_count, output, CNT_W bits: saturating count of presses.

Function
REQ-014 SHALL use FSM states IDLE, PRESSED, HELD, and a hold counter of 16 bits.
REQ-015 SHALL register all outputs; every strobe SHALL assert exactly one cycle, on the clock edge after the edge that samples the causing input.
REQ-016 IDLE, debounced_in=1: go to PRESSED, clear the hold counter, pulse press_pulse, and increment press_count.
REQ-017 PRESSED, debounced_in=1: increment the hold counter; on the cycle the counter reaches LONG_CYCLES-1, go to HELD, pulse long_pulse, and clear the hold counter.
REQ-018 HELD, debounced_in=1: increment the hold counter; when it reaches REPEAT_CYCLES-1, pulse repeat_pulse and clear the counter to 0.
REQ-019 PRESSED or HELD, debounced_in=0: go to IDLE, pulse release_pulse, and clear the hold counter.
REQ-020 Release on the same cycle as the long or repeat threshold SHALL win: release_pulse only, no long_pulse or repeat_pulse.
REQ-021 press_count SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-022 If clear_count and a press occur in the same cycle, clear SHALL have priority and press_count SHALL become 0; press_pulse still fires.
REQ-023 long_active SHALL be high exactly while the state is HELD, i.e. from the long_pulse cycle through the cycle before release_pulse.
REQ-024 At most one of press_pulse, release_pulse, and long_pulse SHALL be high in any cycle.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, hold counter 0, all strobes 0, long_active 0, and press_count 0.
REQ-026 Reset mid-press SHALL produce no release_pulse.
REQ-027 After rst_n rises with debounced_in already 1, the first sampled edge SHALL be treated as a new press (REQ-016).

Structure
REQ-028 Package button_pkg SHALL hold the state enum (IDLE, PRESSED, HELD) and the default LONG_CYCLES, REPEAT_CYCLES, and CNT_W constants.
REQ-029 The hold counter with its threshold compare SHALL be one sub-module, hold_timer, inputs clear/enable/limit, output hit.
REQ-030 The FSM, strobes, and press_count SHALL live in button_event_fsm; expected size is 120-250 RTL lines.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=3)
REQ-031 Reset, then drive debounced_in high for 3 cycles, then low -> press_pulse once, release_pulse once, no long_pulse, press_count=1.
REQ-032 Hold high for 20 cycles -> long_pulse 8 cycles after press_pulse; repeat_pulse at +4, +8, +12 after long_pulse; long_active high from long_pulse until release.
REQ-033 Make 9 short presses -> press_count reads 7 after the 7th press and stays 7.
REQ-034 Release on the exact threshold cycle (high for 8 cycles) -> release_pulse, no long_pulse, long_active stays 0.
REQ-035 Assert clear_count on the cycle a press is sampled, with count=5 -> press_count=0, press_pulse=1.
REQ-036 Assert rst_n low during HELD -> all outputs 0 asynchronously, no release_pulse; with input high, a press_pulse follows release of reset.

Source files
------------

// File: rtl/button_pkg.sv
// Shared state encoding and default timing constants for the button event FSM.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    localparam int unsigned DEF_LONG_CYCLES   = 1000;
    localparam int unsigned DEF_REPEAT_CYCLES = 250;
    localparam int unsigned DEF_CNT_W         = 8;
    localparam int unsigned HOLD_W            = 16;

endpackage

// File: rtl/button_event_fsm_hold_timer.sv
// 16-bit hold counter; hit flags the cycle the count equals limit, and an
// enabled hit rolls the count back to zero so it can re-arm on its own.
module hold_timer
    import button_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [HOLD_W-1:0] limit,
    output logic              hit
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    assign hit = (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = hit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into press/release/long/repeat strobes,
// a long-press level and a saturating press counter; all outputs registered.
module button_event_fsm
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debounced_in,
    input  logic             clear_count,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic             long_active,
    output logic [CNT_W-1:0] press_count
);

    localparam logic [HOLD_W-1:0] LONG_LIMIT   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LIMIT = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              long_active_q, long_active_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              tmr_clear;
    logic              tmr_enable;
    logic              tmr_hit;
    logic [HOLD_W-1:0] tmr_limit;

    hold_timer u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .limit  (tmr_limit),
        .hit    (tmr_hit)
    );

    always_comb begin
        state_d    = state_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        count_d    = count_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        tmr_limit  = (state_q == HELD) ? REPEAT_LIMIT : LONG_LIMIT;

        unique case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                if (debounced_in) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            PRESSED: begin
                // Release is tested first so it beats a coincident threshold.
                if (!debounced_in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    tmr_clear = 1'b1;
                end else if (tmr_hit) begin
                    state_d   = HELD;
                    long_d    = 1'b1;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            HELD: begin
                if (!debounced_in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                    repeat_d   = tmr_hit;
                end
            end
            default: begin
                state_d   = IDLE;
                tmr_clear = 1'b1;
            end
        endcase

        if (clear_count) begin
            count_d = '0;
        end

        long_active_d = (state_d == HELD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            long_active_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            press_q       <= press_d;
            release_q     <= release_d;
            long_q        <= long_d;
            repeat_q      <= repeat_d;
            long_active_q <= long_active_d;
            count_q       <= count_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign long_active   = long_active_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm: directed scenarios with literal expectations
// plus random press/release runs compared every cycle against a press-duration model.
module tb_button_event_fsm;

    localparam int LONG  = 8;
    localparam int REP   = 4;
    localparam int W     = 3;
    localparam int CMAX  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         debounced_in = 1'b0;
    logic         clear_count = 1'b0;
    logic         press_pulse;
    logic         release_pulse;
    logic         long_pulse;
    logic         repeat_pulse;
    logic         long_active;
    logic [W-1:0] press_count;

    int errors = 0;
    int checks = 0;

    button_event_fsm #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .CNT_W         (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .debounced_in  (debounced_in),
        .clear_count   (clear_count),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .long_active   (long_active),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks whether the button is down, how many edges it has been
    // held since the press, and whether it already became long.
    bit m_pressed, m_long;
    int m_n, m_cnt;
    bit e_press, e_release, e_long, e_rep;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pressed <= 0; m_long <= 0; m_n <= 0; m_cnt <= 0;
            e_press <= 0; e_release <= 0; e_long <= 0; e_rep <= 0;
        end else begin : model_step
            bit p, l, ep, er, el, ek;
            int n, c;
            p = m_pressed; l = m_long; n = m_n; c = m_cnt;
            ep = 0; er = 0; el = 0; ek = 0;
            if (!p) begin
                if (debounced_in) begin
                    p = 1; l = 0; n = 0; ep = 1;
                    if (c < CMAX) c = c + 1;
                end
            end else if (!debounced_in) begin
                p = 0; l = 0; er = 1;
            end else begin
                n = n + 1;
                if (!l) begin
                    if (n == LONG) begin l = 1; el = 1; end
                end else if ((n - LONG) % REP == 0) begin
                    ek = 1;
                end
            end
            if (clear_count) c = 0;
            m_pressed <= p; m_long <= l; m_n <= n; m_cnt <= c;
            e_press <= ep; e_release <= er; e_long <= el; e_rep <= ek;
        end
    end

    int n_press = 0, n_release = 0, n_long = 0, max_active = 0;

    always @(negedge clk) begin
        chk("press_pulse",   int'(press_pulse),   int'(e_press));
        chk("release_pulse", int'(release_pulse), int'(e_release));
        chk("long_pulse",    int'(long_pulse),    int'(e_long));
        chk("repeat_pulse",  int'(repeat_pulse),  int'(e_rep));
        chk("long_active",   int'(long_active),   int'(m_long));
        chk("press_count",   int'(press_count),   m_cnt);
        if (press_pulse === 1'b1)   n_press++;
        if (release_pulse === 1'b1) n_release++;
        if (long_pulse === 1'b1)    n_long++;
        if (long_active === 1'b1)   max_active = 1;
    end

    // Called at a falling edge: drive inputs, return at the next falling edge.
    task automatic step(input logic in, input logic clr);
        debounced_in = in;
        clear_count  = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int bp, br, bl;
        repeat (3) @(negedge clk);
        chk("reset_count", int'(press_count), 0);
        chk("reset_active", int'(long_active), 0);
        rst_n = 1'b1;
        step(0, 0);

        // Short press
        bp = n_press; br = n_release; bl = n_long;
        repeat (3) step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("s31_press", n_press - bp, 1);
        chk("s31_release", n_release - br, 1);
        chk("s31_long", n_long - bl, 0);
        chk("s31_count", int'(press_count), 1);

        // Long press with repeats
        for (int i = 0; i < 22; i++) begin
            step(1, 0);
            chk("s32_press", int'(press_pulse), int'(i == 0));
            chk("s32_long", int'(long_pulse), int'(i == 8));
            chk("s32_rep", int'(repeat_pulse), int'(i == 12 || i == 16 || i == 20));
            chk("s32_active", int'(long_active), int'(i >= 8));
        end
        step(0, 0);
        chk("s32_rel", int'(release_pulse), 1);
        chk("s32_rel_active", int'(long_active), 0);

        // Saturation
        step(0, 1);
        for (int p = 1; p <= 9; p++) begin
            step(1, 0);
            chk("s33_count", int'(press_count), (p < 7) ? p : 7);
            step(0, 0);
        end

        // Release exactly on the long threshold
        bl = n_long; max_active = 0;
        repeat (8) step(1, 0);
        step(0, 0);
        chk("s34_release", int'(release_pulse), 1);
        chk("s34_long", n_long - bl, 0);
        chk("s34_active", max_active, 0);

        // Clear coincident with a press
        step(0, 1);
        repeat (5) begin step(1, 0); step(0, 0); end
        chk("s35_pre", int'(press_count), 5);
        step(1, 1);
        chk("s35_press", int'(press_pulse), 1);
        chk("s35_count", int'(press_count), 0);
        step(0, 0);

        // Asynchronous reset while held
        repeat (10) step(1, 0);
        chk("s36_held", int'(long_active), 1);
        br = n_release;
        rst_n = 1'b0;
        #1;
        chk("s36_async_active", int'(long_active), 0);
        chk("s36_async_strobes", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        chk("s36_async_count", int'(press_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1, 0);
        chk("s36_no_release", n_release - br, 0);
        chk("s36_press", int'(press_pulse), 1);
        chk("s36_count", int'(press_count), 1);
        step(0, 0);

        // Random press/release runs
        for (int r = 0; r < 250; r++) begin
            logic lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                step(lvl, 1'($urandom_range(0, 15) == 0));
            end
        end
        step(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
